// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word with a programmable dwell per point.
// Optional feature macro DDS_SWEEP_BIDIR_EN: after the peak point the sweep descends back to f_start.
module dds_sweep_ctrl #(
    parameter int W_TW    = 32,
    parameter int W_N     = 16,
    parameter int W_DWELL = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [W_TW-1:0]    f_start,
    input  logic [W_TW-1:0]    f_step,
    input  logic [W_N-1:0]     n_steps,
    input  logic [W_DWELL-1:0] dwell,
    output logic [W_TW-1:0]    m,
    output logic               set,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [W_N-1:0]     step_idx
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STROBE = 3'd2,
        S_DWELL  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q;
    logic [W_TW-1:0]      m_q;
    logic [W_TW-1:0]      step_q;
    logic [W_N-1:0]       n_q;
    logic [W_N-1:0]       idx_q;
    logic [W_DWELL-1:0]   dwell_q;
    logic [W_DWELL-1:0]   cnt_q;
    logic                 down_q;
    logic                 set_q;
    logic                 en_q;
    logic                 busy_q;
    logic                 done_q;

    logic [W_DWELL-1:0]   dwell_eff_d;
    logic [W_TW-1:0]      nxt_word_d;
    logic [W_N-1:0]       nxt_idx_d;
    logic                 nxt_down_d;
    logic                 last_d;

    // A zero dwell still holds each point for one cycle.
    always_comb begin
        if (dwell == {W_DWELL{1'b0}}) begin
            dwell_eff_d = {{(W_DWELL-1){1'b0}}, 1'b1};
        end else begin
            dwell_eff_d = dwell;
        end
    end

    // Next point of the sweep, or last_d when the current point is the final one.
    always_comb begin
        nxt_word_d = m_q;
        nxt_idx_d  = idx_q;
        nxt_down_d = down_q;
        last_d     = 1'b1;
        if (!down_q) begin
            if (idx_q != n_q) begin
                nxt_word_d = m_q + step_q;
                nxt_idx_d  = idx_q + {{(W_N-1){1'b0}}, 1'b1};
                last_d     = 1'b0;
            end else begin
`ifdef DDS_SWEEP_BIDIR_EN
                // Turn at the peak without repeating it; a zero-step sweep has no descent.
                if (n_q != {W_N{1'b0}}) begin
                    nxt_word_d = m_q - step_q;
                    nxt_idx_d  = idx_q - {{(W_N-1){1'b0}}, 1'b1};
                    nxt_down_d = 1'b1;
                    last_d     = 1'b0;
                end else begin
                    last_d     = 1'b1;
                end
`else
                last_d = 1'b1;
`endif
            end
        end else begin
            if (idx_q != {W_N{1'b0}}) begin
                nxt_word_d = m_q - step_q;
                nxt_idx_d  = idx_q - {{(W_N-1){1'b0}}, 1'b1};
                last_d     = 1'b0;
            end else begin
                last_d     = 1'b1;
            end
        end
    end

    // Sweep FSM; every output is a register updated on entry to the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= {W_TW{1'b0}};
            step_q  <= {W_TW{1'b0}};
            n_q     <= {W_N{1'b0}};
            idx_q   <= {W_N{1'b0}};
            dwell_q <= {W_DWELL{1'b0}};
            cnt_q   <= {W_DWELL{1'b0}};
            down_q  <= 1'b0;
            set_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort && (state_q != S_IDLE)) begin
            state_q <= S_IDLE;
            set_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        m_q     <= f_start;
                        step_q  <= f_step;
                        n_q     <= n_steps;
                        dwell_q <= dwell_eff_d;
                        idx_q   <= {W_N{1'b0}};
                        down_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    set_q   <= 1'b1;
                    en_q    <= 1'b1;
                    state_q <= S_STROBE;
                end
                S_STROBE: begin
                    set_q   <= 1'b0;
                    cnt_q   <= dwell_q - {{(W_DWELL-1){1'b0}}, 1'b1};
                    state_q <= S_DWELL;
                end
                S_DWELL: begin
                    if (cnt_q != {W_DWELL{1'b0}}) begin
                        cnt_q <= cnt_q - {{(W_DWELL-1){1'b0}}, 1'b1};
                    end else if (last_d) begin
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        m_q     <= nxt_word_d;
                        idx_q   <= nxt_idx_d;
                        down_q  <= nxt_down_d;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    set_q   <= 1'b0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m        = m_q;
    assign set      = set_q;
    assign en       = en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected set/done events come from an arithmetic sweep model.
// Honours DDS_SWEEP_BIDIR_EN the same way as the design.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] f_start = 32'h0;
    logic [31:0] f_step = 32'h0;
    logic [15:0] n_steps = 16'h0;
    logic [23:0] dwell = 24'h0;
    logic [31:0] m;
    logic        set;
    logic        en;
    logic        busy;
    logic        done;
    logic [15:0] step_idx;

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [31:0] m;
        logic [15:0] idx;
    } ev_t;

    ev_t sb_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    dds_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
        .m(m), .set(set), .en(en), .busy(busy), .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every set or done pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (set || done)) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event set=%0b done=%0b m=%0h (cyc %0d)", set, done, m, cyc);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                chk("evt_kind", 64'(done), 64'(e.is_done));
                chk("evt_cyc", 64'(cyc), 64'(e.cyc));
                chk("evt_m", 64'(m), 64'(e.m));
                if (e.is_done) begin
                    chk("done_en", 64'(en), 64'd0);
                    chk("done_busy", 64'(busy), 64'd1);
                end else begin
                    chk("set_idx", 64'(step_idx), 64'(e.idx));
                    chk("set_en", 64'(en), 64'd1);
                end
            end
        end
    end

    // Reference model: point p's set pulse lands 1+p*(2+D) cycles after the LOAD cycle c0.
    task automatic push_events(input logic [31:0] fs, input logic [31:0] fst, input int n,
                               input int dw, input int c0, input int lim,
                               output int total, output logic [31:0] held);
        int   d;
        int   t;
        int   np;
        int   pi;
        logic [31:0] w;
        ev_t  e;
        d = (dw == 0) ? 1 : dw;
        t = 2 + d;
`ifdef DDS_SWEEP_BIDIR_EN
        np = 2 * n + 1;
`else
        np = n + 1;
`endif
        total = np * t;
        held  = fs;
        for (int p = 0; p < np; p++) begin
            pi = (p <= n) ? p : (2 * n - p);
            w  = fs + 32'(pi) * fst;
            if (p * t <= lim) held = w;
            if (1 + p * t <= lim) begin
                e.is_done = 1'b0;
                e.cyc     = c0 + 1 + p * t;
                e.m       = w;
                e.idx     = 16'(pi);
                sb_q.push_back(e);
            end
        end
        if (total <= lim) begin
            e.is_done = 1'b1;
            e.cyc     = c0 + total;
            e.m       = held;
            e.idx     = 16'h0;
            sb_q.push_back(e);
        end
    endtask

    // One sweep; abort_at<0 means run to completion, mid_k>=0 pulses a stray start while busy.
    task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fst, input int n,
                             input int dw, input int abort_at, input int mid_k,
                             output logic [31:0] held);
        int c0;
        int total;
        int last_k;
        @(negedge clk);
        f_start = fs;
        f_step  = fst;
        n_steps = 16'(n);
        dwell   = 24'(dw);
        start   = 1'b1;
        abort   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        push_events(fs, fst, n, dw, c0, (abort_at >= 0) ? abort_at : 32'h3fff_ffff, total, held);
        chk("load_busy", 64'(busy), 64'd1);
        f_start = $urandom;
        f_step  = $urandom;
        n_steps = 16'($urandom_range(9, 0));
        dwell   = 24'($urandom_range(9, 0));
        last_k = (abort_at >= 0) ? abort_at : total;
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0) @(negedge clk);
            start = (k == mid_k);
            abort = (k == abort_at);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_en", 64'(en), 64'd0);
        chk("end_set", 64'(set), 64'd0);
        chk("end_done", 64'(done), 64'd0);
        chk("end_m_held", 64'(m), 64'(held));
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        @(negedge clk);
        chk("idle_m_held", 64'(m), 64'(held));
    endtask

    initial begin
        logic [31:0] held;
        int          c0;
        int          total;
        int          n;
        int          dw;
        int          ab;
        int          mk;

        #12;
        chk("rst_m", 64'(m), 64'd0);
        chk("rst_set", 64'(set), 64'd0);
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_idx", 64'(step_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DDS_SWEEP_BIDIR_EN
        run_sweep(32'h0, 32'h1, 2, 1, -1, -1, held);
        chk("t5_final_m", 64'(m), 64'h0);
`else
        run_sweep(32'h100, 32'h10, 3, 4, -1, -1, held);
        chk("t1_final_m", 64'(m), 64'h130);
        run_sweep(32'h8, 32'hFFFF_FFF0, 1, 0, -1, -1, held);
        chk("t2_final_m", 64'(m), 64'hFFFF_FFF8);
        // abort in the second point's dwell (its DWELL cycles sit at offsets 8..11)
        run_sweep(32'h100, 32'h10, 3, 4, 9, -1, held);
        chk("t3_held_m", 64'(m), 64'h110);
`endif

        // stray start while busy
        run_sweep(32'h100, 32'h10, 3, 4, -1, 5, held);

        // start together with abort in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("start_abort_set", 64'(set), 64'd0);

        // reset in the middle of a sweep
        @(negedge clk);
        f_start = 32'h100; f_step = 32'h10; n_steps = 16'd3; dwell = 24'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        push_events(32'h100, 32'h10, 3, 4, c0, 5, total, held);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_m", 64'(m), 64'd0);
        chk("midrst_en", 64'(en), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_idx", 64'(step_idx), 64'd0);
        chk("midrst_sb", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // randomized sweeps, some aborted, some with stray starts
        for (int r = 0; r < 40; r++) begin
            n  = $urandom_range(4, 0);
            dw = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(5, 1);
`ifdef DDS_SWEEP_BIDIR_EN
            total = (2 * n + 1) * (2 + ((dw == 0) ? 1 : dw));
`else
            total = (n + 1) * (2 + ((dw == 0) ? 1 : dw));
`endif
            ab = ($urandom_range(3, 0) == 0) ? $urandom_range(total - 1, 0) : -1;
            mk = ($urandom_range(2, 0) == 0) ? $urandom_range(total - 1, 0) : -1;
            run_sweep($urandom, $urandom, n, dw, ab, mk, held);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
